// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: state and owner
// encodings plus the default line and address widths.
package mem_arbiter_pkg;

  localparam int DEF_LINE_W = 64;
  localparam int DEF_ADDR_W = 14;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WB   = 2'b01;
  localparam logic [1:0] ST_FILL = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache miss service (optional write-back) onto
// one line-wide memory port. Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic              i_done,
  output logic              d_done,
  output logic [LINE_W-1:0] rd_line,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic              m_rdy,
  input  logic [LINE_W-1:0] m_rdata,
  output logic              busy
);

  logic [1:0]        state;
  owner_e            owner_q;
  owner_e            grant;
  logic [ADDR_W-1:0] fill_addr_q;

`ifdef MEM_ARB_RR_EN
  owner_e last_grant;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= OWNER_I;
    else if (state == ST_IDLE && (i_req || d_req))
      last_grant <= grant;
  end
`endif

  // NOTE: combinational blocks assign every output first so no latch can form.
  always_comb begin
    grant = d_req ? OWNER_D : OWNER_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req)
      grant = (last_grant == OWNER_D) ? OWNER_I : OWNER_D;
`endif
  end

  assign busy = (state != ST_IDLE);

  // NOTE: all state uses non-blocking assignment so every register sees the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_q     <= OWNER_I;
      fill_addr_q <= '0;
      m_re        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      rd_line     <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_q <= grant;
            if (grant == OWNER_D) begin
              fill_addr_q <= d_addr;
              if (d_dirty) begin
                state   <= ST_WB;
                m_we    <= 1'b1;
                m_addr  <= d_wb_addr;
                m_wdata <= d_wb_data;
              end else begin
                state  <= ST_FILL;
                m_re   <= 1'b1;
                m_addr <= d_addr;
              end
            end else begin
              fill_addr_q <= i_addr;
              state       <= ST_FILL;
              m_re        <= 1'b1;
              m_addr      <= i_addr;
            end
          end
        end
        ST_WB: begin
          // Entering FILL with m_re still low leaves one idle cycle on the bus.
          if (m_rdy) begin
            m_we  <= 1'b0;
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (m_re && m_rdy) begin
            m_re    <= 1'b0;
            rd_line <= m_rdata;
            state   <= ST_DONE;
            i_done  <= (owner_q == OWNER_I);
            d_done  <= (owner_q == OWNER_D);
          end else if (!m_re) begin
            m_re   <= 1'b1;
            m_addr <= fill_addr_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter; follows MEM_ARB_RR_EN
// to predict tie-break order.
module tb_mem_arbiter;

  localparam int LW = 64;
  localparam int AW = 14;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_dirty;
  logic [AW-1:0] i_addr, d_addr, d_wb_addr;
  logic [LW-1:0] d_wb_data;
  logic          i_done, d_done, m_re, m_we, m_rdy, busy;
  logic [LW-1:0] rd_line, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit last_g = 1'b0;
  op_t ops_q[$];
  int  lat_q[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_dirty(d_dirty), .d_addr(d_addr),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .i_done(i_done), .d_done(d_done), .rd_line(rd_line),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdy(m_rdy), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: answers each strobe after a latency taken from lat_q and logs
  // the completed operation; raises stray m_rdy pulses while the arbiter idles.
  int            cnt = 0;
  int            cur_lat = 1;
  logic [AW-1:0] first_addr;
  bit            prev_we = 1'b0;
  always @(negedge clk) begin
    op_t o;
    check("strobe_excl", m_re & m_we, 0);
    if (prev_we && !m_we) check("wb_gap", m_re, 0);
    prev_we = m_we;
    m_rdata = {$urandom, $urandom};
    if (m_re || m_we) begin
      cnt++;
      if (cnt == 1) begin
        first_addr = m_addr;
        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      end else begin
        check("m_addr_hold", m_addr, first_addr);
      end
      if (cnt == cur_lat) begin
        m_rdy  = 1'b1;
        o.we   = m_we;
        o.addr = m_addr;
        o.data = m_we ? m_wdata : m_rdata;
        ops_q.push_back(o);
      end else begin
        m_rdy = 1'b0;
      end
    end else begin
      cnt   = 0;
      m_rdy = !busy && ($urandom_range(0, 2) == 0);
    end
  end

  // Runs one request pattern from an idle cycle; fixed_lat 0 means random.
  task automatic run_case(input bit ri, input bit rd, input logic [AW-1:0] ia,
                          input logic [AW-1:0] da, input logic [AW-1:0] wa,
                          input bit dirty, input logic [LW-1:0] wd,
                          input int fixed_lat);
    bit            order[2];
    bit            dty[2];
    int            lw[2], lr[2];
    logic [AW-1:0] faddr[2];
    logic [LW-1:0] wdat[2];
    logic [AW-1:0] waddr[2];
    int            n, start, dcyc;
    bit            got_d, tmo;
    op_t           o;

    ops_q.delete();
    lat_q.delete();
    n = 0;
    if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
      order[0] = (last_g == 1'b1) ? 1'b0 : 1'b1;
`else
      order[0] = 1'b1;
`endif
      order[1] = ~order[0];
      n = 2;
    end else if (ri) begin
      order[0] = 1'b0; n = 1;
    end else if (rd) begin
      order[0] = 1'b1; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      dty[k]   = order[k] && dirty;
      faddr[k] = order[k] ? da : ia;
      waddr[k] = wa;
      wdat[k]  = wd;
      lw[k]    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      lr[k]    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      if (dty[k]) lat_q.push_back(lw[k]);
      lat_q.push_back(lr[k]);
      last_g = order[k];
    end

    i_req = ri; d_req = rd; i_addr = ia; d_addr = da;
    d_wb_addr = wa; d_dirty = dirty; d_wb_data = wd;
    start = cyc;

    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check("idle_after_done", busy, 0);
        start = cyc;
      end
      @(negedge clk);
      if (order[k]) begin
        d_addr = AW'($urandom); d_wb_addr = AW'($urandom);
        d_wb_data = {$urandom, $urandom}; d_dirty = ~d_dirty;
        if ($urandom_range(0, 1) == 1) d_req = 1'b0;
      end else begin
        i_addr = AW'($urandom);
        if ($urandom_range(0, 1) == 1) i_req = 1'b0;
      end

      tmo = 1'b1; got_d = 1'b0; dcyc = 0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (i_done || d_done) begin
          got_d = d_done; dcyc = cyc; tmo = 1'b0;
          break;
        end
      end
      if (tmo) begin
        check("done_timeout", i_done | d_done, 1);
        i_req = 1'b0; d_req = 1'b0;
        return;
      end

      check("done_owner", got_d, order[k]);
      check("done_onehot", i_done & d_done, 0);
      check("done_latency", dcyc - start, dty[k] ? lw[k] + lr[k] + 2 : lr[k] + 1);
      check("op_count", ops_q.size(), dty[k] ? 2 : 1);
      if (dty[k] && ops_q.size() > 0) begin
        o = ops_q.pop_front();
        check("wb_is_write", o.we, 1);
        check("wb_addr", o.addr, waddr[k]);
        check("wb_data", o.data, wdat[k]);
      end
      if (ops_q.size() > 0) begin
        o = ops_q.pop_front();
        check("fill_is_read", o.we, 0);
        check("fill_addr", o.addr, faddr[k]);
        check("rd_line", rd_line, o.data);
      end
      if (order[k]) d_req = 1'b0;
      else          i_req = 1'b0;
    end

    @(negedge clk);
    check("done_pulse", i_done | d_done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    bit ri, rd;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_dirty = 1'b0;
    i_addr = '0; d_addr = '0; d_wb_addr = '0; d_wb_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_m_re", m_re, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_rd_line", rd_line, 0);
    check("rst_done", i_done | d_done, 0);
    rst = 1'b0;

    // I-only fill at 0x0123 with a three-cycle memory.
    run_case(1'b1, 1'b0, 14'h0123, 14'h0, 14'h0, 1'b0, 64'h0, 3);
    // Dirty D miss: write-back of the victim line, then the fill.
    run_case(1'b0, 1'b1, 14'h0, 14'h0200, 14'h0040, 1'b1, 64'hDEAD_BEEF_0000_1111, 2);
    // Two consecutive ties.
    run_case(1'b1, 1'b1, 14'h0111, 14'h0222, 14'h0333, 1'b0, 64'h0, 0);
    run_case(1'b1, 1'b1, 14'h0444, 14'h0555, 14'h0666, 1'b1, 64'h1234_5678_9ABC_DEF0, 0);

    // Reset while the write-back is in flight aborts it silently.
    lat_q.delete(); ops_q.delete();
    lat_q.push_back(6); lat_q.push_back(6);
    d_req = 1'b1; d_dirty = 1'b1; d_addr = 14'h0ABC; d_wb_addr = 14'h0DEF;
    d_wb_data = 64'hCAFE_F00D_0000_0001;
    repeat (2) @(negedge clk);
    check("wb_active", m_we, 1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_m_re", m_re, 0);
    check("abort_m_we", m_we, 0);
    check("abort_m_addr", m_addr, 0);
    check("abort_done", i_done | d_done, 0);
    last_g = 1'b0;
    lat_q.delete(); ops_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", i_done | d_done, 0);
      check("abort_idle", busy, 0);
    end

    for (int t = 0; t < 60; t++) begin
      ri = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      if (!ri && !rd) ri = 1'b1;
      run_case(ri, rd, AW'($urandom), AW'($urandom), AW'($urandom),
               $urandom_range(0, 1) == 1, {$urandom, $urandom}, 0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("idle_stay", busy, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

endmodule
